// File: rtl/er_sched_pkg.sv
// ---------------------------------------------------------------------------
// er_sched_pkg
// Shared types and constants for the ER frame scheduler.
//   - sched_state_t : run-level FSM state encoding
//   - per-frame field widths and the derived run accumulator widths
//   - sat_add       : saturating add used by every counter/accumulator
// ---------------------------------------------------------------------------
package er_sched_pkg;

    localparam int FRAME_ROUND_WIDTH       = 8;
    localparam int FRAME_LEAKED_INFO_WIDTH = 16;
    localparam int FRAME_ERROR_COUNT_WIDTH = 14;

    // Run accumulators carry 8 extra bits so a full run rarely saturates.
    localparam int TOTAL_LEAKED_WIDTH = FRAME_LEAKED_INFO_WIDTH + 8;
    localparam int TOTAL_ERROR_WIDTH  = FRAME_ERROR_COUNT_WIDTH + 8;
    localparam int FRAME_COUNT_WIDTH  = 8;

    localparam logic [31:0] TOTAL_LEAKED_MAX = 32'((64'd1 << TOTAL_LEAKED_WIDTH) - 64'd1);
    localparam logic [31:0] TOTAL_ERROR_MAX  = 32'((64'd1 << TOTAL_ERROR_WIDTH) - 64'd1);
    localparam logic [31:0] FRAME_COUNT_MAX  = 32'((64'd1 << FRAME_COUNT_WIDTH) - 64'd1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_KEY = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_START    = 3'd3,
        ST_WAIT_ER  = 3'd4,
        ST_ACCOUNT  = 3'd5,
        ST_RELEASE  = 3'd6,
        ST_DONE     = 3'd7
    } sched_state_t;

    // Saturating add on zero-extended operands; the caller truncates the
    // result back to the accumulator width, so max_val must fit that width.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/er_sched_watchdog.sv
// ---------------------------------------------------------------------------
// er_sched_watchdog
// Per-frame cycle counter for the ER scheduler timeout option.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : frame start; counter restarts at 1 (the start cycle itself)
//   enable     : scheduler is waiting for the ER engines
//   expired    : high while enabled and the count has reached TIMEOUT_CYCLES
// The counter parks at TIMEOUT_CYCLES rather than wrapping.
// ---------------------------------------------------------------------------
module er_sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= CNT_W'(1);
        end else if (enable && (cnt_reg != CNT_LIMIT)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = enable && (cnt_reg == CNT_LIMIT);

endmodule

// File: rtl/er_frame_scheduler.sv
// ---------------------------------------------------------------------------
// er_frame_scheduler
// Run-level sequencer for the Alice/Bob single-frame error-reconciliation
// pair. Per frame: wait for a full sifted-key half, let BRAM/FIFOs settle,
// pulse start_er, collect finish/fail/statistics from both engines, add the
// statistics to the run totals and hand the consumed half back to sifting.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   start_switch           level; rising edge in IDLE (or DONE) starts a run
//   sifted_frame_ready     current half holds a full frame
//   sifted_frame_release   1-cycle pulse, current half consumed
//   start_er               1-cycle start pulse to both ER engines
//   frame_round            frame number, stable from start_er to release
//   sifted_key_addr_index  sifted-key BRAM half in use
//   A_finish/B_finish      engine finish indications
//   A_fail/B_fail          engine verification failure
//   er_leaked_info, er_error_count, er_parameter_valid   A-side statistics
//   total_leaked_info      run leakage total (all frames)
//   total_error_count      run corrected-error total (successful frames)
//   frames_ok, frames_failed   frame outcome counters
//   busy, run_done         run status
//   timeout_err            sticky per-frame watchdog flag
//
// Build option: define ER_SCHED_TIMEOUT_EN to enable the per-frame watchdog;
// otherwise WAIT_ER waits indefinitely and timeout_err stays 0.
// ---------------------------------------------------------------------------
module er_frame_scheduler
    import er_sched_pkg::*;
#(
    parameter int NUM_FRAMES     = 16,
    parameter int START_DELAY    = 128,
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start_switch,
    input  logic                                sifted_frame_ready,
    output logic                                sifted_frame_release,
    output logic                                start_er,
    output logic [FRAME_ROUND_WIDTH-1:0]        frame_round,
    output logic                                sifted_key_addr_index,
    input  logic                                A_finish,
    input  logic                                B_finish,
    input  logic                                A_fail,
    input  logic                                B_fail,
    input  logic [FRAME_LEAKED_INFO_WIDTH-1:0]  er_leaked_info,
    input  logic [FRAME_ERROR_COUNT_WIDTH-1:0]  er_error_count,
    input  logic                                er_parameter_valid,
    output logic [TOTAL_LEAKED_WIDTH-1:0]       total_leaked_info,
    output logic [TOTAL_ERROR_WIDTH-1:0]        total_error_count,
    output logic [FRAME_COUNT_WIDTH-1:0]        frames_ok,
    output logic [FRAME_COUNT_WIDTH-1:0]        frames_failed,
    output logic                                busy,
    output logic                                run_done,
    output logic                                timeout_err
);

    if ((NUM_FRAMES < 1) || (NUM_FRAMES > (1 << FRAME_ROUND_WIDTH))) begin : g_bad_num_frames
        $error("NUM_FRAMES out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    localparam int SETTLE_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(START_DELAY - 1);
    localparam logic [FRAME_ROUND_WIDTH:0] LAST_ROUND_PLUS1 = (FRAME_ROUND_WIDTH + 1)'(NUM_FRAMES);

    sched_state_t                       state_reg, state_next;
    logic                               start_d_reg;
    logic                               restart_reg, restart_next;
    logic [SETTLE_W-1:0]                settle_cnt_reg, settle_cnt_next;
    logic [1:0]                         done_reg, done_next;     // {B, A}
    logic                               fail_reg, fail_next;
    logic                               param_reg, param_next;
    logic [FRAME_LEAKED_INFO_WIDTH-1:0] leaked_reg, leaked_next;
    logic [FRAME_ERROR_COUNT_WIDTH-1:0] err_reg, err_next;
    logic [FRAME_ROUND_WIDTH-1:0]       round_reg, round_next;
    logic                               index_reg, index_next;
    logic [TOTAL_LEAKED_WIDTH-1:0]      tot_leak_reg, tot_leak_next;
    logic [TOTAL_ERROR_WIDTH-1:0]       tot_err_reg, tot_err_next;
    logic [FRAME_COUNT_WIDTH-1:0]       ok_reg, ok_next;
    logic [FRAME_COUNT_WIDTH-1:0]       failed_reg, failed_next;
    logic                               timeout_reg, timeout_next;
    logic                               start_rise;
    logic                               wd_hit;
    logic [FRAME_ROUND_WIDTH:0]         round_plus1;

    assign start_rise  = start_switch && !start_d_reg;
    assign round_plus1 = {1'b0, round_reg} + 1'b1;

`ifdef ER_SCHED_TIMEOUT_EN
    er_sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_reg == ST_START),
        .enable  (state_reg == ST_WAIT_ER),
        .expired (wd_hit)
    );
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            // Track the switch level through reset so a switch already held
            // high does not look like a fresh start once reset releases.
            start_d_reg    <= start_switch;
            restart_reg    <= 1'b0;
            settle_cnt_reg <= '0;
            done_reg       <= '0;
            fail_reg       <= 1'b0;
            param_reg      <= 1'b0;
            leaked_reg     <= '0;
            err_reg        <= '0;
            round_reg      <= '0;
            index_reg      <= 1'b0;
            tot_leak_reg   <= '0;
            tot_err_reg    <= '0;
            ok_reg         <= '0;
            failed_reg     <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_d_reg    <= start_switch;
            restart_reg    <= restart_next;
            settle_cnt_reg <= settle_cnt_next;
            done_reg       <= done_next;
            fail_reg       <= fail_next;
            param_reg      <= param_next;
            leaked_reg     <= leaked_next;
            err_reg        <= err_next;
            round_reg      <= round_next;
            index_reg      <= index_next;
            tot_leak_reg   <= tot_leak_next;
            tot_err_reg    <= tot_err_next;
            ok_reg         <= ok_next;
            failed_reg     <= failed_next;
            timeout_reg    <= timeout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        restart_next    = restart_reg;
        settle_cnt_next = settle_cnt_reg;
        done_next       = done_reg;
        fail_next       = fail_reg;
        param_next      = param_reg;
        leaked_next     = leaked_reg;
        err_next        = err_reg;
        round_next      = round_reg;
        index_next      = index_reg;
        tot_leak_next   = tot_leak_reg;
        tot_err_next    = tot_err_reg;
        ok_next         = ok_reg;
        failed_next     = failed_reg;
        timeout_next    = timeout_reg;

        case (state_reg)
            ST_IDLE: begin
                round_next    = '0;
                index_next    = 1'b0;
                tot_leak_next = '0;
                tot_err_next  = '0;
                ok_next       = '0;
                failed_next   = '0;
                done_next     = '0;
                fail_next     = 1'b0;
                param_next    = 1'b0;
                // restart_reg carries the edge that left DONE through the
                // single IDLE cycle so the new run starts without a second edge.
                if (start_rise || restart_reg) begin
                    restart_next = 1'b0;
                    state_next   = ST_WAIT_KEY;
                end
            end

            ST_WAIT_KEY: begin
                if (sifted_frame_ready) begin
                    settle_cnt_next = '0;
                    state_next      = (START_DELAY == 0) ? ST_START : ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next = ST_START;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end

            ST_START: begin
                done_next   = '0;
                fail_next   = 1'b0;
                param_next  = 1'b0;
                leaked_next = '0;
                err_next    = '0;
                state_next  = ST_WAIT_ER;
            end

            ST_WAIT_ER: begin
                done_next = done_reg | {B_finish, A_finish};
                fail_next = fail_reg | A_fail | B_fail;
                if (er_parameter_valid) begin
                    param_next  = 1'b1;
                    leaked_next = er_leaked_info;
                    err_next    = er_error_count;
                end
                // Exit on the updated latches so the release lands two
                // cycles after the last required event.
                if ((&done_next) && (param_next || fail_next)) begin
                    state_next = ST_ACCOUNT;
                end else if (wd_hit) begin
                    fail_next    = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = ST_ACCOUNT;
                end
            end

            ST_ACCOUNT: begin
                // Leakage is public whatever the outcome, so it always counts.
                tot_leak_next = TOTAL_LEAKED_WIDTH'(sat_add(32'(tot_leak_reg),
                                    32'(leaked_reg), TOTAL_LEAKED_MAX));
                if (fail_reg) begin
                    failed_next = FRAME_COUNT_WIDTH'(sat_add(32'(failed_reg),
                                      32'd1, FRAME_COUNT_MAX));
                end else begin
                    ok_next      = FRAME_COUNT_WIDTH'(sat_add(32'(ok_reg),
                                       32'd1, FRAME_COUNT_MAX));
                    tot_err_next = TOTAL_ERROR_WIDTH'(sat_add(32'(tot_err_reg),
                                       32'(err_reg), TOTAL_ERROR_MAX));
                end
                state_next = ST_RELEASE;
            end

            ST_RELEASE: begin
                index_next = ~index_reg;
                round_next = round_plus1[FRAME_ROUND_WIDTH-1:0];
                state_next = (round_plus1 == LAST_ROUND_PLUS1) ? ST_DONE : ST_WAIT_KEY;
            end

            ST_DONE: begin
                if (start_rise) begin
                    restart_next = 1'b1;
                    state_next   = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign start_er              = (state_reg == ST_START);
    assign sifted_frame_release  = (state_reg == ST_RELEASE);
    assign busy                  = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign run_done              = (state_reg == ST_DONE);
    assign frame_round           = round_reg;
    assign sifted_key_addr_index = index_reg;
    assign total_leaked_info     = tot_leak_reg;
    assign total_error_count     = tot_err_reg;
    assign frames_ok             = ok_reg;
    assign frames_failed         = failed_reg;
    assign timeout_err           = timeout_reg;

endmodule

// File: tb/tb_er_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_er_frame_scheduler
// Directed bench for er_frame_scheduler with NUM_FRAMES=2, START_DELAY=128,
// TIMEOUT_CYCLES=1000. Inputs change 1 ns after a rising edge; outputs are
// sampled at that same point, i.e. they show the state entered at the edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_er_frame_scheduler;
    import er_sched_pkg::*;

    localparam int TB_DELAY = 128;

    logic                                clk = 1'b0;
    logic                                rst_n;
    logic                                start_switch;
    logic                                sifted_frame_ready;
    logic                                sifted_frame_release;
    logic                                start_er;
    logic [FRAME_ROUND_WIDTH-1:0]        frame_round;
    logic                                sifted_key_addr_index;
    logic                                A_finish, B_finish, A_fail, B_fail;
    logic [FRAME_LEAKED_INFO_WIDTH-1:0]  er_leaked_info;
    logic [FRAME_ERROR_COUNT_WIDTH-1:0]  er_error_count;
    logic                                er_parameter_valid;
    logic [TOTAL_LEAKED_WIDTH-1:0]       total_leaked_info;
    logic [TOTAL_ERROR_WIDTH-1:0]        total_error_count;
    logic [FRAME_COUNT_WIDTH-1:0]        frames_ok, frames_failed;
    logic                                busy, run_done, timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int rel_count = 0;
    int start_count = 0;

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (sifted_frame_release === 1'b1) rel_count++;
        if (start_er === 1'b1) start_count++;
    end

    er_frame_scheduler #(
        .NUM_FRAMES     (2),
        .START_DELAY    (TB_DELAY),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start_switch          (start_switch),
        .sifted_frame_ready    (sifted_frame_ready),
        .sifted_frame_release  (sifted_frame_release),
        .start_er              (start_er),
        .frame_round           (frame_round),
        .sifted_key_addr_index (sifted_key_addr_index),
        .A_finish              (A_finish),
        .B_finish              (B_finish),
        .A_fail                (A_fail),
        .B_fail                (B_fail),
        .er_leaked_info        (er_leaked_info),
        .er_error_count        (er_error_count),
        .er_parameter_valid    (er_parameter_valid),
        .total_leaked_info     (total_leaked_info),
        .total_error_count     (total_error_count),
        .frames_ok             (frames_ok),
        .frames_failed         (frames_failed),
        .busy                  (busy),
        .run_done              (run_done),
        .timeout_err           (timeout_err)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic wait_start_er(input string tag);
        int k;
        k = 0;
        while ((start_er !== 1'b1) && (k < 2000)) begin
            step(1);
            k++;
        end
        check(tag, 32'(start_er), 32'd1);
    endtask

    task automatic clear_er_inputs();
        A_finish = 1'b0; B_finish = 1'b0; A_fail = 1'b0; B_fail = 1'b0;
        er_parameter_valid = 1'b0; er_leaked_info = '0; er_error_count = '0;
    endtask

    initial begin
        int rel0;
        int starts0;
        logic seen;

        rst_n = 1'b0; start_switch = 1'b0; sifted_frame_ready = 1'b0;
        clear_er_inputs();

        // ---- reset state ----
        step(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_start_er", 32'(start_er), 0);
        check("rst_release", 32'(sifted_frame_release), 0);
        check("rst_run_done", 32'(run_done), 0);
        check("rst_leaked", 32'(total_leaked_info), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        rst_n = 1'b1;
        sifted_frame_ready = 1'b1;
        step(1);

        // ---- run 1, frame 0: finish 50 cycles after start ----
        start_switch = 1'b1;
        step(1);
        check("run1_busy", 32'(busy), 1);
        step(TB_DELAY);
        check("f0_no_start_early", 32'(start_er), 0);
        step(1);
        check("f0_start_er", 32'(start_er), 1);
        check("f0_index", 32'(sifted_key_addr_index), 0);
        check("f0_round", 32'(frame_round), 0);
        step(1);
        check("f0_start_one_cycle", 32'(start_er), 0);
        step(48);
        A_finish = 1'b1; B_finish = 1'b1; er_parameter_valid = 1'b1;
        er_leaked_info = 16'd100; er_error_count = 14'd7;
        step(1);
        clear_er_inputs();
        check("f0_no_release_account", 32'(sifted_frame_release), 0);
        step(1);
        check("f0_release", 32'(sifted_frame_release), 1);
        check("f0_total_leaked", 32'(total_leaked_info), 100);
        check("f0_total_err", 32'(total_error_count), 7);
        check("f0_frames_ok", 32'(frames_ok), 1);

        // ---- run 1, frame 1: B finishes 10 cycles before A, params last ----
        step(1);
        check("f1_index", 32'(sifted_key_addr_index), 1);
        check("f1_round", 32'(frame_round), 1);
        step(TB_DELAY);
        check("f1_no_start_early", 32'(start_er), 0);
        step(1);
        check("f1_start_er", 32'(start_er), 1);
        step(1);
        rel0 = rel_count;
        step(7);
        B_finish = 1'b1;
        step(1);
        B_finish = 1'b0;
        step(9);
        A_finish = 1'b1;
        step(1);
        A_finish = 1'b0;
        check("f1_wait_params", 32'(busy && !sifted_frame_release), 1);
        step(4);
        er_parameter_valid = 1'b1; er_leaked_info = 16'd100; er_error_count = 14'd7;
        step(1);
        clear_er_inputs();
        check("f1_no_release_account", 32'(sifted_frame_release), 0);
        step(1);
        check("f1_release", 32'(sifted_frame_release), 1);
        step(1);
        check("f1_one_release", 32'(rel_count - rel0), 1);
        check("run1_done", 32'(run_done), 1);
        check("run1_busy_low", 32'(busy), 0);
        check("run1_total_leaked", 32'(total_leaked_info), 200);
        check("run1_total_err", 32'(total_error_count), 14);
        check("run1_frames_ok", 32'(frames_ok), 2);
        check("run1_frames_failed", 32'(frames_failed), 0);

        // ---- run 2, frame 0: fail together with A_finish ----
        start_switch = 1'b0;
        step(1);
        start_switch = 1'b1;
        step(1);
        check("run2_idle_done_low", 32'(run_done), 0);
        check("run2_idle_busy_low", 32'(busy), 0);
        step(1);
        check("run2_cleared_ok", 32'(frames_ok), 0);
        check("run2_cleared_leaked", 32'(total_leaked_info), 0);
        wait_start_er("run2_f0_start_er");
        step(1);
        A_finish = 1'b1; A_fail = 1'b1; er_parameter_valid = 1'b1;
        er_leaked_info = 16'd40; er_error_count = 14'd5;
        step(1);
        clear_er_inputs();
        step(3);
        B_finish = 1'b1;
        step(1);
        B_finish = 1'b0;
        step(1);
        check("fail_release", 32'(sifted_frame_release), 1);
        check("fail_frames_failed", 32'(frames_failed), 1);
        check("fail_frames_ok", 32'(frames_ok), 0);
        check("fail_total_leaked", 32'(total_leaked_info), 40);
        check("fail_total_err", 32'(total_error_count), 0);

        // ---- run 2, frame 1: ready low for 300 cycles ----
        sifted_frame_ready = 1'b0;
        starts0 = start_count;
        step(300);
        check("ready_low_no_start", 32'(start_count - starts0), 0);
        sifted_frame_ready = 1'b1;
        step(TB_DELAY);
        check("ready_no_start_early", 32'(start_er), 0);
        step(1);
        check("ready_start_er", 32'(start_er), 1);

        // ---- reset during WAIT_ER ----
        step(1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_release", 32'(sifted_frame_release), 0);
        check("midrst_failed", 32'(frames_failed), 0);
        check("midrst_leaked", 32'(total_leaked_info), 0);
        check("midrst_round", 32'(frame_round), 0);
        check("midrst_index", 32'(sifted_key_addr_index), 0);
        rel0 = rel_count;
        A_finish = 1'b1; B_finish = 1'b1; er_parameter_valid = 1'b1;
        er_leaked_info = 16'd9;
        step(1);
        clear_er_inputs();
        step(4);
        check("stray_no_release", 32'(rel_count - rel0), 0);
        check("stray_still_idle", 32'(busy), 0);
        check("stray_frames_ok", 32'(frames_ok), 0);

        // ---- watchdog ----
        start_switch = 1'b0;
        step(1);
        start_switch = 1'b1;
        step(1);
        wait_start_er("wd_start_er");
`ifdef ER_SCHED_TIMEOUT_EN
        step(1000);
        check("wd_not_yet", 32'(timeout_err), 0);
        step(1);
        check("wd_timeout_err", 32'(timeout_err), 1);
        step(1);
        check("wd_release", 32'(sifted_frame_release), 1);
        check("wd_frames_failed", 32'(frames_failed), 1);
`else
        rel0 = rel_count;
        seen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            step(1);
            if (busy !== 1'b1) seen = 1'b1;
        end
        check("nowd_left_wait", 32'(seen), 0);
        check("nowd_no_release", 32'(rel_count - rel0), 0);
        check("nowd_timeout_err", 32'(timeout_err), 0);
        check("nowd_frames_failed", 32'(frames_failed), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
